// File: rtl/word_framer.sv
`default_nettype none
// ============================================================================
//  Module      : word_framer
//  Description : Buffers packer words in a FIFO and emits framed packets
//                (header, FRAME_LEN payload words, checksum trailer) on a
//                ready/valid stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_framer #(
  parameter int          SIZE_DATA_BIT = 32,
  parameter int          FRAME_LEN     = 4,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] SYNC_WORD     = 16'hA5C3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SIZE_DATA_BIT-1:0] i_data,
  input  logic                     i_valid,
  output logic [SIZE_DATA_BIT-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic                     o_fifo_full,
  output logic                     o_overflow
);

  localparam int                c_aw         = $clog2(FIFO_DEPTH);
  localparam int                c_cw         = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cw-1:0]   c_depth      = c_cw'(FIFO_DEPTH);
  localparam logic [c_cw-1:0]   c_frame_len  = c_cw'(FRAME_LEN);
  localparam logic [c_cw-1:0]   c_last_beat  = c_cw'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  logic [SIZE_DATA_BIT-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]          r_wr_ptr;
  logic [c_aw-1:0]          r_rd_ptr;
  logic [c_cw-1:0]          r_count;
  logic [c_cw-1:0]          w_count_nxt;
  logic                     w_full;
  logic                     w_wr;
  logic                     w_pop;
  logic                     w_accept;
  logic [SIZE_DATA_BIT-1:0] w_rd_data;

  state_t                   r_state, w_state_nxt;
  logic [SIZE_DATA_BIT-1:0] r_data, w_data_nxt;
  logic                     r_valid, w_valid_nxt;
  logic                     r_sof, w_sof_nxt;
  logic                     r_eof, w_eof_nxt;
  logic [SIZE_DATA_BIT-1:0] r_sum, w_sum_nxt;
  logic [c_cw-1:0]          r_beat, w_beat_nxt;
  logic [15:0]              r_seq, w_seq_nxt;
  logic                     r_full;
  logic                     r_overflow;

  // Fullness uses the pre-edge count, so a simultaneous pop never frees a slot.
  assign w_full    = (r_count == c_depth);
  assign w_wr      = i_valid && !w_full;
  assign w_accept  = r_valid && i_ready;
  assign w_rd_data = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + c_cw'(1);
      2'b01:   w_count_nxt = r_count - c_cw'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_sof_nxt   = r_sof;
    w_eof_nxt   = r_eof;
    w_sum_nxt   = r_sum;
    w_beat_nxt  = r_beat;
    w_seq_nxt   = r_seq;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A frame only starts once its whole payload is already buffered.
        if (r_count >= c_frame_len) begin
          w_valid_nxt = 1'b1;
          w_sof_nxt   = 1'b1;
          w_data_nxt  = SIZE_DATA_BIT'({SYNC_WORD, r_seq});
          w_state_nxt = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (w_accept) begin
          w_pop       = 1'b1;
          w_data_nxt  = w_rd_data;
          w_sof_nxt   = 1'b0;
          w_sum_nxt   = '0;
          w_beat_nxt  = '0;
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_accept) begin
          w_sum_nxt = r_sum + r_data;
          if (r_beat == c_last_beat) begin
            w_data_nxt  = w_sum_nxt;
            w_eof_nxt   = 1'b1;
            w_state_nxt = ST_TRAILER;
          end else begin
            w_pop      = 1'b1;
            w_data_nxt = w_rd_data;
            w_beat_nxt = r_beat + c_cw'(1);
          end
        end
      end
      ST_TRAILER: begin
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          w_eof_nxt   = 1'b0;
          w_seq_nxt   = r_seq + 16'd1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_sum      <= '0;
      r_beat     <= '0;
      r_seq      <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      if (i_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_sof   <= w_sof_nxt;
      r_eof   <= w_eof_nxt;
      r_sum   <= w_sum_nxt;
      r_beat  <= w_beat_nxt;
      r_seq   <= w_seq_nxt;
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_sof       = r_sof;
  assign o_eof       = r_eof;
  assign o_fifo_full = r_full;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_word_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_framer
//  Description : Directed self-checking bench for word_framer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_framer;

  logic        clk;
  logic        reset;
  logic [31:0] i_data;
  logic        i_valid;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_sof;
  logic        o_eof;
  logic        o_fifo_full;
  logic        o_overflow;

  int          n_checks;
  int          n_errors;
  int          cyc;
  logic [33:0] q[$];
  int          qc[$];

  word_framer #(
    .SIZE_DATA_BIT(32),
    .FRAME_LEN    (4),
    .FIFO_DEPTH   (8),
    .SYNC_WORD    (16'hA5C3)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_fifo_full(o_fifo_full),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Each entry is {sof, eof, data} of a word that transfers on the next edge.
  always @(negedge clk) begin
    if (!reset && o_valid && i_ready) begin
      q.push_back({o_sof, o_eof, o_data});
      qc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] w);
    i_valid = 1'b1;
    i_data  = w;
    tick();
    i_valid = 1'b0;
    i_data  = '0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    q.delete();
    qc.delete();
  endtask

  task automatic wait_n(input string tag, input int n);
    for (int i = 0; i < 200 && q.size() < n; i++) tick();
    check(tag, 34'(q.size()), 34'(n));
  endtask

  task automatic wait_word(input string tag, input logic [31:0] w);
    for (int i = 0; i < 50 && !(o_valid && !o_sof && !o_eof && o_data == w); i++) tick();
    check(tag, {o_valid, o_data}, {1'b1, w});
  endtask

  task automatic check_frame(input string tag, input int b, input logic [15:0] seq,
                             input logic [31:0] p0, input logic [31:0] p1,
                             input logic [31:0] p2, input logic [31:0] p3,
                             input logic [31:0] sum);
    logic [31:0] p [4];
    p = '{p0, p1, p2, p3};
    check({tag, "_hdr"}, q[b], {2'b10, 16'hA5C3, seq});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_p%0d", tag, i), q[b+1+i], {2'b00, p[i]});
    end
    check({tag, "_trl"}, q[b+5], {2'b01, sum});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_data   = '0;
    i_ready  = 1'b0;

    // 1. reset state, basic frame and header latency
    do_reset();
    check("rst_valid", 34'(o_valid), 34'd0);
    check("rst_data", 34'(o_data), 34'd0);
    check("rst_flags", 34'({o_sof, o_eof, o_fifo_full, o_overflow}), 34'd0);
    i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) wr(32'(i));
    check("t1_lat0", 34'(o_valid), 34'd0);
    tick();
    check("t1_lat1", 34'({o_valid, o_sof}), 34'd3);
    wait_n("t1_cnt", 6);
    check_frame("t1", 0, 16'h0000, 1, 2, 3, 4, 32'h0000000A);

    // 2. back-to-back frames with an idle gap
    do_reset();
    for (int i = 1; i <= 8; i++) wr(32'(i));
    wait_n("t2_cnt", 12);
    check_frame("t2f0", 0, 16'h0000, 1, 2, 3, 4, 32'h0000000A);
    check_frame("t2f1", 6, 16'h0001, 5, 6, 7, 8, 32'h0000001A);
    check("t2_gap", 34'(qc[6] - qc[5] >= 2), 34'd1);

    // 3. backpressure on the second payload word
    do_reset();
    for (int i = 1; i <= 4; i++) wr(32'(i));
    wait_word("t3_find", 32'd2);
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_hold%0d", i), {o_valid, o_sof, o_eof, o_data}, {3'b100, 32'd2});
    end
    i_ready = 1'b1;
    wait_n("t3_cnt", 6);
    check_frame("t3", 0, 16'h0000, 1, 2, 3, 4, 32'h0000000A);
    tick();
    tick();
    check("t3_nodup", 34'(q.size()), 34'd6);

    // 4. overflow while the sink is stalled
    do_reset();
    i_ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(32'(i));
    check("t4_full8", 34'({o_fifo_full, o_overflow}), 34'b10);
    wr(32'd9);
    check("t4_ovf9", 34'({o_fifo_full, o_overflow}), 34'b11);
    tick();
    tick();
    i_ready = 1'b1;
    wait_n("t4_cnt", 12);
    check_frame("t4f0", 0, 16'h0000, 1, 2, 3, 4, 32'h0000000A);
    check_frame("t4f1", 6, 16'h0001, 5, 6, 7, 8, 32'h0000001A);
    for (int i = 0; i < 5; i++) tick();
    check("t4_drop9", 34'(q.size()), 34'd12);
    check("t4_sticky", 34'({o_fifo_full, o_overflow}), 34'b01);
    do_reset();
    check("t4_ovf_clr", 34'(o_overflow), 34'd0);

    // 5. checksum wraps modulo 2^32
    i_ready = 1'b1;
    wr(32'hFFFFFFFF);
    wr(32'd2);
    wr(32'd0);
    wr(32'd0);
    wait_n("t5_cnt", 6);
    check_frame("t5", 0, 16'h0000, 32'hFFFFFFFF, 2, 0, 0, 32'h00000001);

    // 6. reset after the second payload accept aborts the frame
    do_reset();
    for (int i = 1; i <= 4; i++) wr(32'(i));
    wait_word("t6_find", 32'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_out", {o_valid, o_sof, o_eof, o_data}, 35'd0);
    check("t6_rst_full", 34'(o_fifo_full), 34'd0);
    q.delete();
    qc.delete();
    for (int i = 0; i < 4; i++) tick();
    check("t6_idle", 34'(o_valid), 34'd0);
    for (int i = 5; i <= 8; i++) wr(32'(i));
    wait_n("t6_cnt", 6);
    check_frame("t6", 0, 16'h0000, 5, 6, 7, 8, 32'h0000001A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
